// File: rtl/decode_pkg.sv
// decode_pkg
// Shared definitions for the decode/issue stage:
//   - RISC-V major opcode values for the recognised instruction classes
//   - opcode_class_t : classification of the 7-bit major opcode
//   - decode_info_t  : per-instruction decode summary (source usage,
//                      destination write, load flag, illegal flag, fields)
//   - classify()/decode() : pure combinational decode helpers
package decode_pkg;

   localparam logic [6:0] OPC_LOAD     = 7'b0000011;
   localparam logic [6:0] OPC_STORE    = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
   localparam logic [6:0] OPC_JALR     = 7'b1100111;
   localparam logic [6:0] OPC_JAL      = 7'b1101111;
   localparam logic [6:0] OPC_LUI      = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
   localparam logic [6:0] OPC_OPIMM    = 7'b0010011;
   localparam logic [6:0] OPC_OP       = 7'b0110011;
   localparam logic [6:0] OPC_OPIMM32  = 7'b0011011;
   localparam logic [6:0] OPC_OP32     = 7'b0111011;

   // Register fields are 5 bits wide in the instruction encoding.
   localparam int REG_FIELD_W = 5;

   typedef enum logic [3:0] {
      CLS_LOAD,
      CLS_STORE,
      CLS_BRANCH,
      CLS_JALR,
      CLS_JAL,
      CLS_LUI,
      CLS_AUIPC,
      CLS_OPIMM,
      CLS_OP,
      CLS_OPIMM32,
      CLS_OP32,
      CLS_ILLEGAL
   } opcode_class_t;

   typedef struct packed {
      logic                   uses_rs1;
      logic                   uses_rs2;
      logic                   rd_write;
      logic                   is_load;
      logic                   illegal;
      logic [REG_FIELD_W-1:0] rs1;
      logic [REG_FIELD_W-1:0] rs2;
      logic [REG_FIELD_W-1:0] rd;
   } decode_info_t;

   function automatic opcode_class_t classify(input logic [6:0] opcode);
      opcode_class_t cls;
      case (opcode)
         OPC_LOAD:    cls = CLS_LOAD;
         OPC_STORE:   cls = CLS_STORE;
         OPC_BRANCH:  cls = CLS_BRANCH;
         OPC_JALR:    cls = CLS_JALR;
         OPC_JAL:     cls = CLS_JAL;
         OPC_LUI:     cls = CLS_LUI;
         OPC_AUIPC:   cls = CLS_AUIPC;
         OPC_OPIMM:   cls = CLS_OPIMM;
         OPC_OP:      cls = CLS_OP;
         OPC_OPIMM32: cls = CLS_OPIMM32;
         OPC_OP32:    cls = CLS_OP32;
         default:     cls = CLS_ILLEGAL;
      endcase
      return cls;
   endfunction

   function automatic decode_info_t decode(input logic [31:0] instr);
      decode_info_t  info;
      opcode_class_t cls;
      cls           = classify(instr[6:0]);
      info.rs1      = instr[19:15];
      info.rs2      = instr[24:20];
      info.rd       = instr[11:7];
      info.illegal  = (cls == CLS_ILLEGAL);
      info.is_load  = (cls == CLS_LOAD);
      // Illegal opcodes read nothing and write nothing.
      info.uses_rs1 = !info.illegal &&
                      (cls != CLS_LUI) && (cls != CLS_AUIPC) && (cls != CLS_JAL);
      info.uses_rs2 = (cls == CLS_STORE) || (cls == CLS_BRANCH) ||
                      (cls == CLS_OP)    || (cls == CLS_OP32);
      info.rd_write = !info.illegal && (cls != CLS_STORE) && (cls != CLS_BRANCH) &&
                      (info.rd != '0);
      return info;
   endfunction

endpackage

// File: rtl/decode_issue_stage_if.sv
// decode_issue_stage_if
// Handshake bundle between fetch, the decode/issue stage and execute.
//   Fetch side : f_valid, f_ready, f_instruction, f_pc
//   Execute    : flush, e_ready
//   Issue side : issue_valid, issue_instruction, issue_pc, issue_rs1/rs2/rd,
//                issue_rd_write, issue_is_load, issue_illegal
// modport master : surrounding pipeline (drives fetch data, flush, e_ready)
// modport slave  : the decode/issue stage
interface decode_issue_stage_if #(
   parameter int XLEN               = 64,
   parameter int INSTRUCTION_LENGTH = 32,
   parameter int REGISTER_SIZE      = 5
) ();

   logic                          f_valid;
   logic                          f_ready;
   logic [INSTRUCTION_LENGTH-1:0] f_instruction;
   logic [XLEN-1:0]               f_pc;
   logic                          flush;
   logic                          e_ready;
   logic                          issue_valid;
   logic [INSTRUCTION_LENGTH-1:0] issue_instruction;
   logic [XLEN-1:0]               issue_pc;
   logic [REGISTER_SIZE-1:0]      issue_rs1;
   logic [REGISTER_SIZE-1:0]      issue_rs2;
   logic [REGISTER_SIZE-1:0]      issue_rd;
   logic                          issue_rd_write;
   logic                          issue_is_load;
   logic                          issue_illegal;

   modport master (
      output f_valid, f_instruction, f_pc, flush, e_ready,
      input  f_ready, issue_valid, issue_instruction, issue_pc,
             issue_rs1, issue_rs2, issue_rd,
             issue_rd_write, issue_is_load, issue_illegal
   );

   modport slave (
      input  f_valid, f_instruction, f_pc, flush, e_ready,
      output f_ready, issue_valid, issue_instruction, issue_pc,
             issue_rs1, issue_rs2, issue_rd,
             issue_rd_write, issue_is_load, issue_illegal
   );

endinterface

// File: rtl/issue_scoreboard.sv
// issue_scoreboard
// Per-register countdown scoreboard for read-after-write hazards against
// multi-cycle (load) producers.
//   clk, rst                 : clock, synchronous active-high reset
//   query_rs1/2, query_use1/2: source registers of the held instruction
//   busy1, busy2             : source has an outstanding load result
//   update_en                : an instruction writing rd completed issue
//   update_rd, update_is_load: its destination and whether it is a load
module issue_scoreboard #(
   parameter int REGISTER_SIZE = 5,
   parameter int LOAD_LATENCY  = 3
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [REGISTER_SIZE-1:0] query_rs1,
   input  logic                     query_use1,
   input  logic [REGISTER_SIZE-1:0] query_rs2,
   input  logic                     query_use2,
   output logic                     busy1,
   output logic                     busy2,
   input  logic                     update_en,
   input  logic [REGISTER_SIZE-1:0] update_rd,
   input  logic                     update_is_load
);

   localparam int NUM_REGS = 2 ** REGISTER_SIZE;
   localparam int CNT_W    = (LOAD_LATENCY > 1) ? $clog2(LOAD_LATENCY) : 1;
   // A load result is forwardable LOAD_LATENCY cycles after issue, so the
   // consumer must wait LOAD_LATENCY-1 cycles.
   localparam logic [CNT_W-1:0] LOAD_INIT = CNT_W'(LOAD_LATENCY - 1);

   logic [NUM_REGS-1:0] busy_vec;

   generate
      for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_cnt
         logic [CNT_W-1:0] cnt_reg;
         logic [CNT_W-1:0] cnt_next;

         always_comb begin
            cnt_next = cnt_reg;
            if (cnt_reg != '0) begin
               cnt_next = cnt_reg - CNT_W'(1);
            end
            // A fresh producer overrides the decrement of the old value.
            if (update_en && (update_rd == REGISTER_SIZE'(gi))) begin
               cnt_next = update_is_load ? LOAD_INIT : '0;
            end
         end

         always_ff @(posedge clk) begin
            if (rst) begin
               cnt_reg <= '0;
            end else begin
               cnt_reg <= cnt_next;
            end
         end

         assign busy_vec[gi] = (cnt_reg != '0);
      end
   endgenerate

   // x0 is hardwired zero and can never be a pending producer.
   assign busy1 = query_use1 && (query_rs1 != '0) && busy_vec[query_rs1];
   assign busy2 = query_use2 && (query_rs2 != '0) && busy_vec[query_rs2];

endmodule

// File: rtl/decode_issue_stage.sv
// decode_issue_stage
// One-entry decode/issue stage between fetch and execute. Holds one
// instruction, decodes it combinationally, stalls on load-use hazards via
// issue_scoreboard and counts hazard stall cycles.
//   clk, rst           : clock, synchronous active-high reset
//   bus (slave)        : fetch handshake, flush, e_ready, issue outputs
//   rf_read_addr1/2    : register file read addresses (held rs1/rs2)
//   rf_read_enable1/2  : held instruction uses that source
//   stall_count        : saturating count of hazard-stall cycles
module decode_issue_stage
   import decode_pkg::*;
#(
   parameter int XLEN               = 64,
   parameter int INSTRUCTION_LENGTH = 32,
   parameter int REGISTER_SIZE      = 5,
   parameter int LOAD_LATENCY       = 3,
   parameter int STALL_CNT_WIDTH    = 32
) (
   input  logic                       clk,
   input  logic                       rst,
   decode_issue_stage_if.slave        bus,
   output logic [REGISTER_SIZE-1:0]   rf_read_addr1,
   output logic [REGISTER_SIZE-1:0]   rf_read_addr2,
   output logic                       rf_read_enable1,
   output logic                       rf_read_enable2,
   output logic [STALL_CNT_WIDTH-1:0] stall_count
);

   logic                          hold_valid_reg, hold_valid_next;
   logic [INSTRUCTION_LENGTH-1:0] hold_instr_reg, hold_instr_next;
   logic [XLEN-1:0]               hold_pc_reg, hold_pc_next;
   logic [STALL_CNT_WIDTH-1:0]    stall_count_reg, stall_count_next;

   decode_info_t             info;
   logic [REGISTER_SIZE-1:0] rs1, rs2, rd;
   logic                     use1, use2;
   logic                     busy1, busy2;
   logic                     hazard;
   logic                     issue_valid;
   logic                     fire;
   logic                     f_ready;
   logic                     accept;

   assign info = decode(hold_instr_reg[31:0]);
   assign rs1  = REGISTER_SIZE'(info.rs1);
   assign rs2  = REGISTER_SIZE'(info.rs2);
   assign rd   = REGISTER_SIZE'(info.rd);
   assign use1 = hold_valid_reg && info.uses_rs1;
   assign use2 = hold_valid_reg && info.uses_rs2;

   issue_scoreboard #(
      .REGISTER_SIZE (REGISTER_SIZE),
      .LOAD_LATENCY  (LOAD_LATENCY)
   ) u_scoreboard (
      .clk            (clk),
      .rst            (rst),
      .query_rs1      (rs1),
      .query_use1     (use1),
      .query_rs2      (rs2),
      .query_use2     (use2),
      .busy1          (busy1),
      .busy2          (busy2),
      .update_en      (fire && info.rd_write),
      .update_rd      (rd),
      .update_is_load (info.is_load)
   );

   assign hazard      = busy1 || busy2;
   assign issue_valid = hold_valid_reg && !hazard && !bus.flush;
   assign fire        = issue_valid && bus.e_ready;
   // flush is deliberately absent here: an incoming instruction during a
   // flush is accepted by the handshake and then discarded.
   assign f_ready     = !hold_valid_reg || fire;
   assign accept      = bus.f_valid && f_ready && !bus.flush;

   always_comb begin
      hold_valid_next = hold_valid_reg;
      hold_instr_next = hold_instr_reg;
      hold_pc_next    = hold_pc_reg;
      if (bus.flush) begin
         hold_valid_next = 1'b0;
      end else if (accept) begin
         hold_valid_next = 1'b1;
         hold_instr_next = bus.f_instruction;
         hold_pc_next    = bus.f_pc;
      end else if (fire) begin
         hold_valid_next = 1'b0;
      end
   end

   // Only hazard stalls are counted; execute backpressure is not.
   always_comb begin
      stall_count_next = stall_count_reg;
      if (hazard && !bus.flush && (stall_count_reg != '1)) begin
         stall_count_next = stall_count_reg + STALL_CNT_WIDTH'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         hold_valid_reg  <= 1'b0;
         hold_instr_reg  <= '0;
         hold_pc_reg     <= '0;
         stall_count_reg <= '0;
      end else begin
         hold_valid_reg  <= hold_valid_next;
         hold_instr_reg  <= hold_instr_next;
         hold_pc_reg     <= hold_pc_next;
         stall_count_reg <= stall_count_next;
      end
   end

   assign bus.f_ready           = f_ready;
   assign bus.issue_valid       = issue_valid;
   assign bus.issue_instruction = hold_instr_reg;
   assign bus.issue_pc          = hold_pc_reg;
   assign bus.issue_rs1         = rs1;
   assign bus.issue_rs2         = rs2;
   assign bus.issue_rd          = rd;
   assign bus.issue_rd_write    = info.rd_write;
   assign bus.issue_is_load     = info.is_load;
   assign bus.issue_illegal     = info.illegal;

   assign rf_read_addr1   = rs1;
   assign rf_read_addr2   = rs2;
   assign rf_read_enable1 = use1;
   assign rf_read_enable2 = use2;
   assign stall_count     = stall_count_reg;

endmodule

// File: tb/tb_decode_issue_stage.sv
// tb_decode_issue_stage
// Directed bench for decode_issue_stage: each scenario task drives fetch /
// execute stimulus on the falling edge and checks outputs 1ns later.
module tb_decode_issue_stage;

   localparam logic [31:0] I_ADDI_X1   = 32'h0050_0093; // addi x1,x0,5
   localparam logic [31:0] I_ADD_X2    = 32'h0010_8133; // add  x2,x1,x1
   localparam logic [31:0] I_LD_X5     = 32'h0005_3283; // ld   x5,0(x10)
   localparam logic [31:0] I_ADD_X6_X5 = 32'h0002_8333; // add  x6,x5,x0
   localparam logic [31:0] I_LD_X0     = 32'h0005_3003; // ld   x0,0(x10)
   localparam logic [31:0] I_ADD_X6_X0 = 32'h0000_0333; // add  x6,x0,x0
   localparam logic [31:0] I_ADD_X7_X5 = 32'h0002_83B3; // add  x7,x5,x0
   localparam logic [31:0] I_ILLEGAL   = 32'h0000_01FF; // opcode 1111111, rd=3
   localparam logic [31:0] I_ADD_X4_X3 = 32'h0001_8233; // add  x4,x3,x0

   logic        clk = 1'b0;
   logic        rst;
   logic [4:0]  rf_read_addr1, rf_read_addr2;
   logic        rf_read_enable1, rf_read_enable2;
   logic [31:0] stall_count;

   int vectors     = 0;
   int miscompares = 0;
   int fire_count  = 0;

   always #5 clk = ~clk;

   decode_issue_stage_if #(.XLEN(64), .INSTRUCTION_LENGTH(32), .REGISTER_SIZE(5)) bus ();

   decode_issue_stage #(
      .XLEN(64), .INSTRUCTION_LENGTH(32), .REGISTER_SIZE(5),
      .LOAD_LATENCY(3), .STALL_CNT_WIDTH(32)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .bus             (bus),
      .rf_read_addr1   (rf_read_addr1),
      .rf_read_addr2   (rf_read_addr2),
      .rf_read_enable1 (rf_read_enable1),
      .rf_read_enable2 (rf_read_enable2),
      .stall_count     (stall_count)
   );

   // One line per completed issue transaction.
   always @(posedge clk) begin
      if (!rst && bus.issue_valid && bus.e_ready) begin
         fire_count++;
         $display("issue pc=%h instr=%h", bus.issue_pc, bus.issue_instruction);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic drive(input logic fv, input logic [31:0] ins, input logic [63:0] pc,
                        input logic fl, input logic er);
      @(negedge clk);
      bus.f_valid       = fv;
      bus.f_instruction = ins;
      bus.f_pc          = pc;
      bus.flush         = fl;
      bus.e_ready       = er;
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      bus.f_valid = 1'b0; bus.flush = 1'b0; bus.e_ready = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      bus.f_instruction = '0; bus.f_pc = '0;
      do_reset();
      #1;
      vectors++; if (bus.issue_valid !== 1'b0) begin miscompares++; $display("FAIL reset_issue_valid: got %b exp 0", bus.issue_valid); end
      vectors++; if (bus.f_ready !== 1'b1) begin miscompares++; $display("FAIL reset_f_ready: got %b exp 1", bus.f_ready); end
      vectors++; if (stall_count !== 32'd0) begin miscompares++; $display("FAIL reset_stall_count: got %0d exp 0", stall_count); end
   endtask

   task automatic test_alu_chain();
      do_reset();
      drive(1'b1, I_ADDI_X1, 64'h100, 1'b0, 1'b1);
      vectors++; if (bus.f_ready !== 1'b1) begin miscompares++; $display("FAIL alu_f_ready_empty: got %b exp 1", bus.f_ready); end
      drive(1'b1, I_ADD_X2, 64'h104, 1'b0, 1'b1);
      vectors++; if (bus.issue_valid !== 1'b1) begin miscompares++; $display("FAIL alu_addi_issue: got %b exp 1", bus.issue_valid); end
      vectors++; if (bus.issue_pc !== 64'h100) begin miscompares++; $display("FAIL alu_addi_pc: got %h exp 100", bus.issue_pc); end
      vectors++; if (bus.issue_rd !== 5'd1 || bus.issue_rd_write !== 1'b1) begin miscompares++; $display("FAIL alu_addi_rd: got rd=%0d wr=%b exp rd=1 wr=1", bus.issue_rd, bus.issue_rd_write); end
      vectors++; if (rf_read_enable1 !== 1'b1 || rf_read_enable2 !== 1'b0) begin miscompares++; $display("FAIL alu_addi_rf_en: got %b%b exp 10", rf_read_enable1, rf_read_enable2); end
      vectors++; if (bus.f_ready !== 1'b1) begin miscompares++; $display("FAIL alu_f_ready_fire: got %b exp 1", bus.f_ready); end
      drive(1'b0, 32'h0, 64'h0, 1'b0, 1'b1);
      vectors++; if (bus.issue_valid !== 1'b1 || bus.issue_pc !== 64'h104) begin miscompares++; $display("FAIL alu_add_issue: got v=%b pc=%h exp v=1 pc=104", bus.issue_valid, bus.issue_pc); end
      vectors++; if (rf_read_addr1 !== 5'd1 || rf_read_addr2 !== 5'd1 || rf_read_enable2 !== 1'b1) begin miscompares++; $display("FAIL alu_add_rf: got a1=%0d a2=%0d en2=%b exp 1 1 1", rf_read_addr1, rf_read_addr2, rf_read_enable2); end
      drive(1'b0, 32'h0, 64'h0, 1'b0, 1'b1);
      vectors++; if (bus.issue_valid !== 1'b0) begin miscompares++; $display("FAIL alu_drained: got %b exp 0", bus.issue_valid); end
      vectors++; if (stall_count !== 32'd0) begin miscompares++; $display("FAIL alu_stall_count: got %0d exp 0", stall_count); end
   endtask

   task automatic test_load_use();
      do_reset();
      drive(1'b1, I_LD_X5, 64'h300, 1'b0, 1'b1);
      drive(1'b1, I_ADD_X6_X5, 64'h304, 1'b0, 1'b1);
      vectors++; if (bus.issue_valid !== 1'b1 || bus.issue_is_load !== 1'b1 || bus.issue_rd !== 5'd5) begin miscompares++; $display("FAIL lu_load_issue: got v=%b ld=%b rd=%0d exp 1 1 5", bus.issue_valid, bus.issue_is_load, bus.issue_rd); end
      for (int i = 0; i < 2; i++) begin
         drive(1'b0, 32'h0, 64'h0, 1'b0, 1'b1);
         vectors++; if (bus.issue_valid !== 1'b0 || bus.f_ready !== 1'b0) begin miscompares++; $display("FAIL lu_stall_%0d: got v=%b rdy=%b exp 0 0", i, bus.issue_valid, bus.f_ready); end
         vectors++; if (stall_count !== 32'(i)) begin miscompares++; $display("FAIL lu_stall_count_%0d: got %0d exp %0d", i, stall_count, i); end
      end
      vectors++; if (bus.issue_pc !== 64'h304 || rf_read_addr1 !== 5'd5) begin miscompares++; $display("FAIL lu_held: got pc=%h a1=%0d exp 304 5", bus.issue_pc, rf_read_addr1); end
      drive(1'b0, 32'h0, 64'h0, 1'b0, 1'b1);
      vectors++; if (bus.issue_valid !== 1'b1) begin miscompares++; $display("FAIL lu_use_issue: got %b exp 1", bus.issue_valid); end
      vectors++; if (stall_count !== 32'd2) begin miscompares++; $display("FAIL lu_stall_total: got %0d exp 2", stall_count); end
      drive(1'b0, 32'h0, 64'h0, 1'b0, 1'b1);
      vectors++; if (bus.issue_valid !== 1'b0) begin miscompares++; $display("FAIL lu_drained: got %b exp 0", bus.issue_valid); end
   endtask

   task automatic test_load_x0();
      do_reset();
      drive(1'b1, I_LD_X0, 64'h380, 1'b0, 1'b1);
      drive(1'b1, I_ADD_X6_X0, 64'h384, 1'b0, 1'b1);
      vectors++; if (bus.issue_is_load !== 1'b1 || bus.issue_rd_write !== 1'b0) begin miscompares++; $display("FAIL x0_load_rd_write: got ld=%b wr=%b exp 1 0", bus.issue_is_load, bus.issue_rd_write); end
      drive(1'b0, 32'h0, 64'h0, 1'b0, 1'b1);
      vectors++; if (bus.issue_valid !== 1'b1 || bus.issue_pc !== 64'h384) begin miscompares++; $display("FAIL x0_no_stall: got v=%b pc=%h exp 1 384", bus.issue_valid, bus.issue_pc); end
      vectors++; if (stall_count !== 32'd0) begin miscompares++; $display("FAIL x0_stall_count: got %0d exp 0", stall_count); end
   endtask

   task automatic test_flush();
      do_reset();
      drive(1'b1, I_LD_X5, 64'h400, 1'b0, 1'b1);
      drive(1'b1, I_ADD_X6_X5, 64'h404, 1'b0, 1'b1);
      drive(1'b0, 32'h0, 64'h0, 1'b0, 1'b1);
      vectors++; if (bus.issue_valid !== 1'b0) begin miscompares++; $display("FAIL fl_stall: got %b exp 0", bus.issue_valid); end
      // Flush during the stall, with an instruction offered that must be dropped.
      drive(1'b1, I_ADD_X7_X5, 64'h500, 1'b1, 1'b1);
      vectors++; if (bus.issue_valid !== 1'b0) begin miscompares++; $display("FAIL fl_no_issue: got %b exp 0", bus.issue_valid); end
      drive(1'b0, 32'h0, 64'h0, 1'b0, 1'b1);
      vectors++; if (bus.issue_valid !== 1'b0 || bus.f_ready !== 1'b1) begin miscompares++; $display("FAIL fl_cleared: got v=%b rdy=%b exp 0 1", bus.issue_valid, bus.f_ready); end
      vectors++; if (stall_count !== 32'd1) begin miscompares++; $display("FAIL fl_stall_count: got %0d exp 1", stall_count); end
      drive(1'b1, I_ADD_X7_X5, 64'h508, 1'b0, 1'b1);
      drive(1'b0, 32'h0, 64'h0, 1'b0, 1'b1);
      vectors++; if (bus.issue_valid !== 1'b1 || bus.issue_pc !== 64'h508) begin miscompares++; $display("FAIL fl_next_issue: got v=%b pc=%h exp 1 508", bus.issue_valid, bus.issue_pc); end
      vectors++; if (stall_count !== 32'd1) begin miscompares++; $display("FAIL fl_stall_final: got %0d exp 1", stall_count); end
   endtask

   task automatic test_backpressure();
      int fires_before;
      do_reset();
      fires_before = fire_count;
      drive(1'b1, I_ADDI_X1, 64'h200, 1'b0, 1'b1);
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, I_ADD_X2, 64'h204, 1'b0, 1'b0);
         vectors++; if (bus.issue_valid !== 1'b1 || bus.f_ready !== 1'b0) begin miscompares++; $display("FAIL bp_hold_%0d: got v=%b rdy=%b exp 1 0", i, bus.issue_valid, bus.f_ready); end
         vectors++; if (bus.issue_pc !== 64'h200 || bus.issue_instruction !== I_ADDI_X1) begin miscompares++; $display("FAIL bp_stable_%0d: got pc=%h ins=%h exp 200 %h", i, bus.issue_pc, bus.issue_instruction, I_ADDI_X1); end
      end
      vectors++; if (stall_count !== 32'd0) begin miscompares++; $display("FAIL bp_not_counted: got %0d exp 0", stall_count); end
      drive(1'b1, I_ADD_X2, 64'h204, 1'b0, 1'b1);
      vectors++; if (bus.f_ready !== 1'b1) begin miscompares++; $display("FAIL bp_release: got %b exp 1", bus.f_ready); end
      // Held ADD has no hazard; flush alone must suppress its issue.
      drive(1'b0, 32'h0, 64'h0, 1'b1, 1'b1);
      vectors++; if (bus.issue_valid !== 1'b0 || bus.issue_pc !== 64'h204) begin miscompares++; $display("FAIL bp_flush_kill: got v=%b pc=%h exp 0 204", bus.issue_valid, bus.issue_pc); end
      drive(1'b0, 32'h0, 64'h0, 1'b0, 1'b1);
      vectors++; if (bus.issue_valid !== 1'b0 || bus.f_ready !== 1'b1) begin miscompares++; $display("FAIL bp_after_flush: got v=%b rdy=%b exp 0 1", bus.issue_valid, bus.f_ready); end
      vectors++; if (fire_count - fires_before !== 1) begin miscompares++; $display("FAIL bp_single_fire: got %0d exp 1", fire_count - fires_before); end
   endtask

   task automatic test_illegal();
      do_reset();
      drive(1'b1, I_ILLEGAL, 64'h600, 1'b0, 1'b1);
      drive(1'b1, I_ADD_X4_X3, 64'h604, 1'b0, 1'b1);
      vectors++; if (bus.issue_illegal !== 1'b1 || bus.issue_valid !== 1'b1) begin miscompares++; $display("FAIL ill_flag: got ill=%b v=%b exp 1 1", bus.issue_illegal, bus.issue_valid); end
      vectors++; if (rf_read_enable1 !== 1'b0 || rf_read_enable2 !== 1'b0 || bus.issue_rd_write !== 1'b0) begin miscompares++; $display("FAIL ill_no_use: got en=%b%b wr=%b exp 00 0", rf_read_enable1, rf_read_enable2, bus.issue_rd_write); end
      drive(1'b0, 32'h0, 64'h0, 1'b0, 1'b1);
      vectors++; if (bus.issue_valid !== 1'b1 || bus.issue_illegal !== 1'b0 || bus.issue_pc !== 64'h604) begin miscompares++; $display("FAIL ill_next: got v=%b ill=%b pc=%h exp 1 0 604", bus.issue_valid, bus.issue_illegal, bus.issue_pc); end
   endtask

   task automatic test_reset_mid_stall();
      do_reset();
      drive(1'b1, I_LD_X5, 64'h700, 1'b0, 1'b1);
      drive(1'b1, I_ADD_X6_X5, 64'h704, 1'b0, 1'b1);
      drive(1'b0, 32'h0, 64'h0, 1'b0, 1'b1);
      @(negedge clk);
      rst = 1'b1;
      #1;
      vectors++; if (stall_count !== 32'd1) begin miscompares++; $display("FAIL rms_before: got %0d exp 1", stall_count); end
      @(negedge clk);
      rst = 1'b0;
      #1;
      vectors++; if (stall_count !== 32'd0 || bus.issue_valid !== 1'b0 || bus.f_ready !== 1'b1) begin miscompares++; $display("FAIL rms_after: got sc=%0d v=%b rdy=%b exp 0 0 1", stall_count, bus.issue_valid, bus.f_ready); end
   endtask

   initial begin
      rst = 1'b1;
      bus.f_valid = 1'b0; bus.f_instruction = '0; bus.f_pc = '0;
      bus.flush = 1'b0; bus.e_ready = 1'b1;
      test_reset();
      test_alu_chain();
      test_load_use();
      test_load_x0();
      test_flush();
      test_backpressure();
      test_illegal();
      test_reset_mid_stall();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
